// File: rtl/projeto1_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// One accepted transfer per cycle; out-of-range accesses are absorbed and flagged.
module projeto1_onchip_mem_arbiter #(
    parameter int DEPTH = 4093,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_address,
    input  logic [3:0]    m0_byteenable,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [31:0]   m0_writedata,
    output logic          m0_waitrequest,
    output logic [31:0]   m0_readdata,
    output logic          m0_readdatavalid,
    input  logic [AW-1:0] m1_address,
    input  logic [3:0]    m1_byteenable,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [31:0]   m1_writedata,
    output logic          m1_waitrequest,
    output logic [31:0]   m1_readdata,
    output logic          m1_readdatavalid,
    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic          mem_clken,
    input  logic [31:0]   mem_readdata,
    output logic          err_oor,
    output logic [AW-1:0] err_addr,
    input  logic          err_clear
);

    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    logic          last_grant;
    logic          pend_valid;
    logic          pend_tag;
    logic          pend_inr;

    logic          req0;
    logic          req1;
    logic          grant_any;
    logic          grant_sel;
    logic          g_is_write;
    logic [AW-1:0] g_addr;
    logic [3:0]    g_be;
    logic [31:0]   g_wdata;
    logic          in_range;

    always_comb begin
        req0      = m0_read | m0_write;
        req1      = m1_read | m1_write;
        grant_any = ~reset & (req0 | req1);
        // Contest goes to whoever did not win last; a lone requester always wins.
        if (req0 && req1) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = req1;
        end
        g_is_write = grant_sel ? m1_write      : m0_write;
        g_addr     = grant_sel ? m1_address    : m0_address;
        g_be       = grant_sel ? m1_byteenable : m0_byteenable;
        g_wdata    = grant_sel ? m1_writedata  : m0_writedata;
        in_range   = {1'b0, g_addr} < DEPTH_X;
    end

    assign m0_waitrequest = reset | (req0 & ~(grant_any & ~grant_sel));
    assign m1_waitrequest = reset | (req1 & ~(grant_any &  grant_sel));

    assign mem_address    = g_addr;
    assign mem_byteenable = g_be;
    assign mem_writedata  = g_wdata;
    assign mem_chipselect = grant_any & in_range;
    assign mem_write      = grant_any & g_is_write & in_range;
    assign mem_clken      = ~reset;

    // Gating with reset kills a read accepted just before reset asserts.
    assign m0_readdatavalid = pend_valid & ~reset & ~pend_tag;
    assign m1_readdatavalid = pend_valid & ~reset &  pend_tag;
    assign m0_readdata      = (m0_readdatavalid & pend_inr) ? mem_readdata : 32'h0000_0000;
    assign m1_readdata      = (m1_readdatavalid & pend_inr) ? mem_readdata : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            pend_valid <= 1'b0;
            pend_tag   <= 1'b0;
            pend_inr   <= 1'b0;
            err_oor    <= 1'b0;
            err_addr   <= '0;
        end else begin
            if (grant_any) begin
                last_grant <= grant_sel;
            end
            pend_valid <= grant_any & ~g_is_write;
            pend_tag   <= grant_sel;
            pend_inr   <= in_range;
            // A clear wins over an error arriving in the same cycle.
            if (err_clear) begin
                err_oor  <= 1'b0;
                err_addr <= '0;
            end else if (grant_any && !in_range) begin
                err_oor <= 1'b1;
                if (!err_oor) begin
                    err_addr <= g_addr;
                end
            end
        end
    end

endmodule
